// File: rtl/matrix_stream_loader.sv
// Dibit-stream matrix-pair loader: parses an M/K/N header, stores A row-major and B column-major, serves rows/columns.
// Optional trailing XOR checksum byte enabled by defining MATRIX_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for a rising axiiv
// HDR    | collecting the three dimension bytes
// LOAD_A | writing A elements row-major
// LOAD_B | writing B elements column-major
// TAIL   | frame body complete, ignoring padding (checksum byte first when enabled)
// DONE   | frame accepted, complete=1
// ERR    | frame rejected, frame_err=1 until the next rising axiiv
module matrix_stream_loader #(
  parameter int ELEM_W = 8,
  parameter int MAX_M  = 16,
  parameter int MAX_K  = 16,
  parameter int MAX_N  = 16,
  parameter int IDX_W  = $clog2((MAX_M > MAX_N) ? MAX_M : MAX_N)
) (
  input  logic                      eth_refclk,
  input  logic                      rst,
  input  logic                      axiiv,
  input  logic [1:0]                axiid,
  input  logic                      rd_req,
  input  logic                      rd_is_b,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_valid,
  output logic [MAX_K*ELEM_W-1:0]   rd_data,
  output logic [7:0]                dim_m,
  output logic [7:0]                dim_k,
  output logic [7:0]                dim_n,
  output logic                      complete,
  output logic                      frame_err
);

  localparam int ELEM_BYTES = ELEM_W / 8;
  localparam int EB_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
  localparam int KW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam logic [EB_W-1:0] EB_LAST = EB_W'(ELEM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, LOAD_A, LOAD_B, TAIL, DONE, ERR} state_t;
  state_t state, state_nx;

  logic [1:0]  dibit_cnt;
  logic [5:0]  dibit_sr;
  logic        axiiv_q;
  logic        byte_vld;
  logic [7:0]  byte_dat;
  logic        rise;

  logic [EB_W-1:0]   ebyte;
  logic [ELEM_W-1:0] elem_acc;
  logic [ELEM_W-1:0] elem_word;
  logic              elem_last_byte;
  logic              elem_done;
  logic              loading;

  logic [IDX_W-1:0] out_cnt;
  logic [KW-1:0]    in_cnt;
  logic             in_last;
  logic             out_last;

  logic [1:0] hdr_cnt;
  logic [7:0] hdr_m;
  logic [7:0] hdr_k;
  logic       hdr_done;
  logic       hdr_ok;

  logic a_we;
  logic b_we;
  logic tail_ok;

  logic [ELEM_W-1:0] mem_a [MAX_M][MAX_K];
  logic [ELEM_W-1:0] mem_b [MAX_N][MAX_K];

  logic [MAX_K*ELEM_W-1:0] rd_mux;
  logic                    rd_hit;

  // Byte assembly: LSB dibit first, byte presented on the cycle its 4th dibit arrives.
  assign byte_vld = axiiv && (dibit_cnt == 2'd3);
  assign byte_dat = {axiid, dibit_sr};
  assign rise     = axiiv && !axiiv_q;

  // axiiv_q resets high so a frame still in flight when reset releases is not seen as a new start.
  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      dibit_cnt <= '0;
      dibit_sr  <= '0;
      axiiv_q   <= 1'b1;
    end else begin
      axiiv_q <= axiiv;
      if (!axiiv) begin
        dibit_cnt <= '0;
      end else begin
        dibit_cnt <= dibit_cnt + 2'd1;
        dibit_sr  <= {axiid, dibit_sr[5:2]};
      end
    end
  end

  assign loading        = (state == LOAD_A) || (state == LOAD_B);
  assign elem_last_byte = byte_vld && (ebyte == EB_LAST);
  assign elem_done      = loading && elem_last_byte;

  always_comb begin
    elem_word = elem_acc;
    for (int i = 0; i < ELEM_BYTES; i++) begin
      if (ebyte == EB_W'(i)) elem_word[i*8 +: 8] = byte_dat;
    end
  end

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      ebyte    <= '0;
      elem_acc <= '0;
    end else if (!loading) begin
      ebyte <= '0;
    end else if (byte_vld) begin
      ebyte    <= elem_last_byte ? '0 : ebyte + EB_W'(1);
      elem_acc <= elem_word;
    end
  end

  // Header capture and validation; dims update only when the header is accepted.
  assign hdr_done = (state == HDR) && byte_vld && (hdr_cnt == 2'd2);
  assign hdr_ok   = (hdr_m != 8'd0) && (hdr_k != 8'd0) && (byte_dat != 8'd0) &&
                    (hdr_m <= 8'(MAX_M)) && (hdr_k <= 8'(MAX_K)) && (byte_dat <= 8'(MAX_N));

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      hdr_cnt <= '0;
      hdr_m   <= '0;
      hdr_k   <= '0;
      dim_m   <= '0;
      dim_k   <= '0;
      dim_n   <= '0;
    end else begin
      if (state != HDR) begin
        hdr_cnt <= '0;
      end else if (byte_vld) begin
        hdr_cnt <= hdr_cnt + 2'd1;
        if (hdr_cnt == 2'd0) hdr_m <= byte_dat;
        if (hdr_cnt == 2'd1) hdr_k <= byte_dat;
      end
      if (hdr_done && hdr_ok) begin
        dim_m <= hdr_m;
        dim_k <= hdr_k;
        dim_n <= byte_dat;
      end
    end
  end

  // out_cnt is the A row or B column, in_cnt walks K; both wrap to 0 at the A/B boundary.
  assign in_last  = (8'(in_cnt) == dim_k - 8'd1);
  assign out_last = (8'(out_cnt) == ((state == LOAD_B) ? dim_n : dim_m) - 8'd1);

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      out_cnt <= '0;
      in_cnt  <= '0;
    end else if (state == HDR) begin
      out_cnt <= '0;
      in_cnt  <= '0;
    end else if (elem_done) begin
      if (in_last) begin
        in_cnt  <= '0;
        out_cnt <= out_last ? '0 : out_cnt + IDX_W'(1);
      end else begin
        in_cnt <= in_cnt + KW'(1);
      end
    end
  end

  always_ff @(posedge eth_refclk) begin
    if (a_we) mem_a[out_cnt][in_cnt] <= elem_word;
    if (b_we) mem_b[out_cnt][in_cnt] <= elem_word;
  end

`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;
  logic       csum_seen;
  logic       csum_ok;

  // The first byte seen in TAIL is the checksum; it must equal the XOR of everything before it.
  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      csum_acc  <= '0;
      csum_seen <= 1'b0;
      csum_ok   <= 1'b0;
    end else begin
      if (rise) csum_acc <= '0;
      else if (byte_vld) csum_acc <= csum_acc ^ byte_dat;
      if (state != TAIL) begin
        csum_seen <= 1'b0;
        csum_ok   <= 1'b0;
      end else if (byte_vld && !csum_seen) begin
        csum_seen <= 1'b1;
        csum_ok   <= (byte_dat == csum_acc);
      end
    end
  end

  assign tail_ok = csum_seen && csum_ok;
`else
  assign tail_ok = 1'b1;
`endif

  always_ff @(posedge eth_refclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (rise) state_nx = HDR;
      HDR: begin
        if (!axiiv)        state_nx = ERR;
        else if (hdr_done) state_nx = hdr_ok ? LOAD_A : ERR;
      end
      LOAD_A: begin
        if (!axiiv)                                     state_nx = ERR;
        else if (elem_done && in_last && out_last)      state_nx = LOAD_B;
      end
      LOAD_B: begin
        if (!axiiv)                                     state_nx = ERR;
        else if (elem_done && in_last && out_last)      state_nx = TAIL;
      end
      TAIL: if (!axiiv) state_nx = tail_ok ? DONE : ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    complete  = (state == DONE);
    frame_err = (state == ERR);
    a_we      = (state == LOAD_A) && elem_last_byte;
    b_we      = (state == LOAD_B) && elem_last_byte;
  end

  // Columns k >= dim_k are masked so stale storage never leaks into a response.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < MAX_K; k++) begin
      if (k < int'(dim_k))
        rd_mux[k*ELEM_W +: ELEM_W] = rd_is_b ? mem_b[rd_idx][k] : mem_a[rd_idx][k];
    end
  end

  assign rd_hit = complete && (8'(rd_idx) < (rd_is_b ? dim_n : dim_m));

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= (rd_req && rd_hit) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: directed and random frames checked against a byte-level frame model.
// Follows MATRIX_LOADER_CHECKSUM_EN the same way the design does.
module tb_matrix_stream_loader;
  localparam int ELEM_W = 8;
  localparam int MAX_M  = 16;
  localparam int MAX_K  = 16;
  localparam int MAX_N  = 16;
  localparam int IDX_W  = 4;
  localparam int EB     = ELEM_W / 8;
  localparam int DW     = MAX_K * ELEM_W;

  typedef byte unsigned bq_t[$];

  logic             eth_refclk = 1'b0;
  logic             rst = 1'b1;
  logic             axiiv = 1'b0;
  logic [1:0]       axiid = 2'd0;
  logic             rd_req = 1'b0;
  logic             rd_is_b = 1'b0;
  logic [IDX_W-1:0] rd_idx = '0;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;
  logic [7:0]       dim_m, dim_k, dim_n;
  logic             complete, frame_err;

  int checks = 0;
  int failures = 0;

  int          m_dm = 0, m_dk = 0, m_dn = 0;
  bit          m_complete = 0, m_err = 0;
  int unsigned ma [MAX_M][MAX_K];
  int unsigned mb [MAX_N][MAX_K];

  matrix_stream_loader dut (
    .eth_refclk(eth_refclk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .rd_req(rd_req), .rd_is_b(rd_is_b), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .complete(complete), .frame_err(frame_err)
  );

  always #5 eth_refclk = ~eth_refclk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int body_len(int m, int k, int n);
    return 3 + (m * k + k * n) * EB;
  endfunction

  function automatic bq_t build(int m, int k, int n, bit seq, int pad);
    bq_t q;
    byte unsigned x = 8'd0;
    int ne = (m * k + k * n) * EB;
    q.push_back(8'(m));
    q.push_back(8'(k));
    q.push_back(8'(n));
    for (int i = 0; i < ne; i++) q.push_back(seq ? 8'(i + 1) : 8'($urandom));
`ifdef MATRIX_LOADER_CHECKSUM_EN
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`endif
    for (int i = 0; i < pad; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic int unsigned elem_at(bq_t fr, int base);
    int unsigned v = 0;
    for (int b = 0; b < EB; b++) v |= int'(fr[base + b]) << (8 * b);
    return v;
  endfunction

  // Outcome of sending the first nd dibits of fr, derived from the frame rules alone.
  function automatic void model_frame(bq_t fr, int nd);
    int nb = nd / 4;
    int m, k, n, need;
    byte unsigned x = 8'd0;
    m_complete = 0;
    m_err = 0;
    if (nb < 3) begin m_err = 1; return; end
    m = fr[0]; k = fr[1]; n = fr[2];
    if (m == 0 || k == 0 || n == 0 || m > MAX_M || k > MAX_K || n > MAX_N) begin
      m_err = 1;
      return;
    end
    m_dm = m; m_dk = k; m_dn = n;
    need = body_len(m, k, n);
`ifdef MATRIX_LOADER_CHECKSUM_EN
    need++;
`endif
    if (nb < need) begin m_err = 1; return; end
`ifdef MATRIX_LOADER_CHECKSUM_EN
    for (int i = 0; i < need - 1; i++) x ^= fr[i];
    if (x != fr[need - 1]) begin m_err = 1; return; end
`endif
    for (int r = 0; r < m; r++)
      for (int c = 0; c < k; c++) ma[r][c] = elem_at(fr, 3 + (r * k + c) * EB);
    for (int c = 0; c < n; c++)
      for (int j = 0; j < k; j++) mb[c][j] = elem_at(fr, 3 + m * k * EB + (c * k + j) * EB);
    m_complete = 1;
  endfunction

  function automatic logic [DW-1:0] exp_row(bit is_b, int idx);
    logic [DW-1:0] v = '0;
    if (!m_complete) return v;
    if (idx >= (is_b ? m_dn : m_dm)) return v;
    for (int k = 0; k < m_dk; k++)
      v[k*ELEM_W +: ELEM_W] = ELEM_W'(is_b ? mb[idx][k] : ma[idx][k]);
    return v;
  endfunction

  // rst_at >= 0 pulses reset for two cycles starting at that dibit while the stream keeps going.
  task automatic send(input bq_t fr, input int nd, input int rst_at);
    for (int i = 0; i < nd; i++) begin
      @(negedge eth_refclk);
      axiiv = 1'b1;
      axiid = 2'(fr[i / 4] >> (2 * (i % 4)));
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
    end
    @(negedge eth_refclk);
    axiiv = 1'b0;
    axiid = 2'd0;
    rst   = 1'b0;
    repeat (3) @(negedge eth_refclk);
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".complete"}, DW'(complete), DW'(m_complete));
    chk({tag, ".frame_err"}, DW'(frame_err), DW'(m_err));
    chk({tag, ".dims"}, DW'({dim_m, dim_k, dim_n}), DW'({8'(m_dm), 8'(m_dk), 8'(m_dn)}));
  endtask

  task automatic run_frame(input bq_t fr, input int nd, input string tag);
    model_frame(fr, nd);
    send(fr, nd, -1);
    check_status(tag);
  endtask

  task automatic read_one(input bit is_b, input int idx, output logic [DW-1:0] d);
    @(negedge eth_refclk);
    rd_req = 1'b1; rd_is_b = is_b; rd_idx = IDX_W'(idx);
    @(negedge eth_refclk);
    rd_req = 1'b0;
    d = rd_data;
    chk("read_one.valid", DW'(rd_valid), DW'(1));
  endtask

  // Back-to-back requests, one per cycle, each response checked the cycle after its request.
  task automatic read_burst(input bit is_b, input int first, input int cnt, input string tag);
    logic [DW-1:0] e_prev = '0;
    int idx;
    for (int i = 0; i <= cnt; i++) begin
      @(negedge eth_refclk);
      if (i > 0) begin
        chk({tag, ".valid"}, DW'(rd_valid), DW'(1));
        chk({tag, ".data"}, rd_data, e_prev);
      end
      if (i < cnt) begin
        idx = (first + i) % 16;
        rd_req = 1'b1; rd_is_b = is_b; rd_idx = IDX_W'(idx);
        e_prev = exp_row(is_b, idx);
      end else begin
        rd_req = 1'b0;
      end
    end
    @(negedge eth_refclk);
    chk({tag, ".idle"}, DW'(rd_valid), DW'(0));
  endtask

  initial begin
    bq_t fr;
    logic [DW-1:0] d;
    int m, k, n, nd, need;

    repeat (3) @(negedge eth_refclk);
    rst = 1'b0;
    repeat (3) @(negedge eth_refclk);
    chk("reset.rd_valid", DW'(rd_valid), DW'(0));
    chk("reset.rd_data", rd_data, '0);
    check_status("reset");

    // Directed 2x3 * 3x2 frame with A=1..6, B=7..12.
    fr = build(2, 3, 2, 1'b1, 0);
    run_frame(fr, fr.size() * 4, "basic");
    read_one(1'b0, 1, d);
    chk("basic.a_row1", d, DW'(24'h060504));
    read_one(1'b1, 0, d);
    chk("basic.b_col0", d, DW'(24'h090807));
    read_burst(1'b0, 0, 4, "basic.a");
    read_burst(1'b1, 0, 4, "basic.b");

    fr = build(2, MAX_K + 1, 2, 1'b0, 0);
    run_frame(fr, fr.size() * 4, "k_too_big");
    read_one(1'b0, 0, d);
    chk("k_too_big.read", d, '0);

    fr = build(2, 3, 2, 1'b0, 0);
    run_frame(fr, 7 * 4 + 2, "short");
    read_one(1'b1, 0, d);
    chk("short.read", d, '0);
    fr = build(3, 2, 4, 1'b0, 0);
    run_frame(fr, fr.size() * 4, "after_short");
    read_burst(1'b0, 0, 4, "after_short.a");
    read_burst(1'b1, 0, 5, "after_short.b");

    fr = build(4, 5, 3, 1'b0, 20);
    run_frame(fr, fr.size() * 4, "padded");
    read_burst(1'b0, 0, 16, "padded.a");
    read_burst(1'b1, 0, 16, "padded.b");

    // Reset two bytes into LOAD_B (body starts at byte 9 for 2x3x2) with the stream still running.
    fr = build(2, 3, 2, 1'b0, 4);
    send(fr, fr.size() * 4, (9 + 2) * 4 + 1);
    m_complete = 0; m_err = 0; m_dm = 0; m_dk = 0; m_dn = 0;
    check_status("rst_mid");
    chk("rst_mid.rd_valid", DW'(rd_valid), DW'(0));
    chk("rst_mid.rd_data", rd_data, '0);
    read_one(1'b0, 0, d);
    chk("rst_mid.read", d, '0);
    fr = build(5, 4, 6, 1'b0, 2);
    run_frame(fr, fr.size() * 4, "after_rst");
    read_burst(1'b0, 0, 6, "after_rst.a");
    read_burst(1'b1, 0, 7, "after_rst.b");

    // Flip the byte right after B: the checksum when enabled, otherwise plain padding.
    fr = build(3, 3, 3, 1'b0, 3);
    need = body_len(3, 3, 3);
    fr[need] = fr[need] ^ 8'h01;
    run_frame(fr, fr.size() * 4, "post_b_flip");
    read_burst(1'b0, 0, 4, "post_b_flip.a");

    // Stop exactly after the last B byte: complete without checksum, rejected with it.
    fr = build(2, 2, 2, 1'b0, 0);
    run_frame(fr, body_len(2, 2, 2) * 4, "end_at_b");
    read_burst(1'b1, 0, 3, "end_at_b.b");

    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(1, MAX_M);
      k = $urandom_range(1, MAX_K);
      n = $urandom_range(1, MAX_N);
      if ($urandom_range(0, 5) == 0) m = $urandom_range(0, 1) ? 0 : MAX_M + 1;
      fr = build(m, k, n, 1'b0, $urandom_range(0, 6));
      nd = fr.size() * 4;
      if ($urandom_range(0, 3) == 0) nd = $urandom_range(1, nd);
      run_frame(fr, nd, $sformatf("rnd%0d", it));
      read_burst(1'b0, $urandom_range(0, 15), 16, $sformatf("rnd%0d.a", it));
      read_burst(1'b1, $urandom_range(0, 15), 16, $sformatf("rnd%0d.b", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
